// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: reads opcode/operand byte pairs from program memory
// and presents them to the fetch stage as 16-bit segments with their next-PC.
module inst_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [7:0]        NOP_OPCODE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_req,
  input  logic              pm_ack,
  input  logic [7:0]        pm_rdata,
  output logic [15:0]       seg_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic              seg_valid,
  input  logic              seg_ready,
  input  logic              l_pc,
  input  logic [ADDR_W-1:0] pc_target
);

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    FETCH_OP = 2'd1,
    FETCH_OR = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [7:0]        r_opcode_hold;
  logic [15:0]       r_seg_out;
  logic [ADDR_W-1:0] r_npc_out;
  logic              r_seg_valid;
  logic              w_pm_req;
  logic              w_op_take;
  logic              w_or_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FLUSH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A redirect overrides every transition and also masks both byte captures.
  always_comb begin
    w_next_state = r_state;
    w_pm_req     = 1'b0;
    unique case (r_state)
      FLUSH: begin
        w_next_state = FETCH_OP;
      end
      FETCH_OP: begin
        w_pm_req = 1'b1;
        if (pm_ack) w_next_state = FETCH_OR;
      end
      FETCH_OR: begin
        w_pm_req = !r_seg_valid || seg_ready;
        if (w_pm_req && pm_ack) w_next_state = FETCH_OP;
      end
      default: begin
        w_next_state = FLUSH;
      end
    endcase
    if (l_pc) w_next_state = FLUSH;
    w_op_take = (r_state == FETCH_OP) && pm_ack && !l_pc;
    w_or_take = (r_state == FETCH_OR) && w_pm_req && pm_ack && !l_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_opcode_hold <= 8'h00;
      r_seg_out     <= {NOP_OPCODE, 8'h00};
      r_npc_out     <= RESET_PC;
      r_seg_valid   <= 1'b0;
    end else begin
      if (l_pc) begin
        r_fetch_pc <= pc_target;
      end else if (w_op_take || w_or_take) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
      if (w_op_take) begin
        r_opcode_hold <= pm_rdata;
      end
      if (w_or_take) begin
        r_seg_out <= {r_opcode_hold, pm_rdata};
        r_npc_out <= r_fetch_pc + ADDR_W'(1);
      end
      // A load on the same edge as a consume keeps the buffer occupied.
      if (l_pc) begin
        r_seg_valid <= 1'b0;
      end else if (w_or_take) begin
        r_seg_valid <= 1'b1;
      end else if (seg_ready) begin
        r_seg_valid <= 1'b0;
      end
    end
  end

  assign pm_addr   = r_fetch_pc;
  assign pm_req    = w_pm_req;
  assign seg_out   = r_seg_out;
  assign npc_out   = r_npc_out;
  assign seg_valid = r_seg_valid;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a memory model with programmable wait
// states feeds the DUT while a negedge monitor scores each consumed segment.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pmAddr;
  logic        pmReq;
  logic        pmAck;
  logic [7:0]  pmRdata;
  logic [15:0] segOut;
  logic [7:0]  npcOut;
  logic        segValid;
  logic        segReady;
  logic        lPc;
  logic [7:0]  pcTarget;

  logic [7:0]  mem [256];
  int          waitCycles;
  int          waitCnt;
  logic [23:0] expQ [$];
  int          assertCount;
  int          failCount;

  inst_fetch_unit #(
    .ADDR_W(8),
    .RESET_PC(8'h00),
    .NOP_OPCODE(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pm_addr(pmAddr),
    .pm_req(pmReq),
    .pm_ack(pmAck),
    .pm_rdata(pmRdata),
    .seg_out(segOut),
    .npc_out(npcOut),
    .seg_valid(segValid),
    .seg_ready(segReady),
    .l_pc(lPc),
    .pc_target(pcTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers once a request has been held for waitCycles cycles.
  assign pmAck   = (waitCnt >= waitCycles);
  assign pmRdata = mem[pmAddr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= 0;
    end else if (!pmReq || pmAck) begin
      waitCnt <= 0;
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redirect, input logic [7:0] target);
    segReady = ready;
    lPc      = redirect;
    pcTarget = target;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each valid&&ready cycle is one transfer; score it against the queue head.
  always @(negedge clk) begin
    if (rst_n && segValid && segReady) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_segment: got %h/%h expected none at %0t", segOut, npcOut, $time);
      end else begin
        logic [23:0] e;
        e = expQ.pop_front();
        checkOutput("seg_out", segOut, e[23:8]);
        checkOutput("npc_out", {8'h00, npcOut}, {8'h00, e[7:0]});
      end
    end
  end

  initial begin
    logic [12:0] s3Valid;
    logic [7:0]  s3Addr [13];
    assertCount = 0;
    failCount   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h00] = 8'h58;
    mem[8'h01] = 8'h2A;
    mem[8'h02] = 8'h81;
    mem[8'h03] = 8'h05;
    mem[8'h50] = 8'hC3;
    mem[8'h51] = 8'h7E;
    mem[8'hFF] = 8'h0B;
    waitCycles = 0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick(2);

    $display("[TB] scenario 1: zero-wait fetch");
    checkOutput("reset_pm_req", {15'h0, pmReq}, 16'h0000);
    checkOutput("reset_seg_valid", {15'h0, segValid}, 16'h0000);
    checkOutput("reset_seg_out", segOut, 16'h0000);
    checkOutput("reset_npc_out", {8'h00, npcOut}, 16'h0000);
    checkOutput("reset_pm_addr", {8'h00, pmAddr}, 16'h0000);
    expQ.push_back({16'h582A, 8'h02});
    expQ.push_back({16'h8105, 8'h04});
    rst_n = 1'b1;
    tick(2);
    checkOutput("s1_valid_e2", {15'h0, segValid}, 16'h0000);
    tick(1);
    checkOutput("s1_valid_e3", {15'h0, segValid}, 16'h0001);
    tick(1);
    checkOutput("s1_valid_e4", {15'h0, segValid}, 16'h0000);
    tick(1);
    checkOutput("s1_valid_e5", {15'h0, segValid}, 16'h0001);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    $display("[TB] scenario 2: output backpressure");
    rst_n = 1'b0;
    tick(1);
    expQ.push_back({16'h582A, 8'h02});
    expQ.push_back({16'h8105, 8'h04});
    rst_n = 1'b1;
    tick(3);
    checkOutput("s2_req_op", {15'h0, pmReq}, 16'h0001);
    checkOutput("s2_addr_op", {8'h00, pmAddr}, 16'h0002);
    for (int i = 4; i <= 6; i++) begin
      tick(1);
      checkOutput("s2_req_held", {15'h0, pmReq}, 16'h0000);
      checkOutput("s2_addr_held", {8'h00, pmAddr}, 16'h0003);
      checkOutput("s2_seg_hold", segOut, 16'h582A);
      checkOutput("s2_valid_hold", {15'h0, segValid}, 16'h0001);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    #1;
    checkOutput("s2_req_release", {15'h0, pmReq}, 16'h0001);
    tick(1);
    checkOutput("s2_valid_reload", {15'h0, segValid}, 16'h0001);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    $display("[TB] scenario 3: two wait cycles per byte");
    rst_n = 1'b0;
    waitCycles = 2;
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(1);
    expQ.push_back({16'h582A, 8'h02});
    expQ.push_back({16'h8105, 8'h04});
    s3Valid = 13'b1_0000_0100_0000;
    s3Addr  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02,
                8'h02, 8'h02, 8'h03, 8'h03, 8'h03, 8'h04};
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      checkOutput("s3_req", {15'h0, pmReq}, 16'h0001);
      checkOutput("s3_addr", {8'h00, pmAddr}, {8'h00, s3Addr[e-1]});
      checkOutput("s3_valid", {15'h0, segValid}, {15'h0, s3Valid[e-1]});
    end
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(1);

    $display("[TB] scenario 4: redirect during operand fetch");
    rst_n = 1'b0;
    waitCycles = 0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(1);
    expQ.push_back({16'h582A, 8'h02});
    expQ.push_back({16'hC37E, 8'h52});
    rst_n = 1'b1;
    tick(4);
    applyStimulus(1'b1, 1'b1, 8'h40);
    #1;
    checkOutput("s4_req_or", {15'h0, pmReq}, 16'h0001);
    checkOutput("s4_addr_or", {8'h00, pmAddr}, 16'h0003);
    tick(1);
    checkOutput("s4_valid_drop", {15'h0, segValid}, 16'h0000);
    checkOutput("s4_req_flush", {15'h0, pmReq}, 16'h0000);
    checkOutput("s4_addr_40", {8'h00, pmAddr}, 16'h0040);
    checkOutput("s4_seg_kept", segOut, 16'h582A);
    applyStimulus(1'b1, 1'b1, 8'h50);
    tick(1);
    checkOutput("s4_req_flush2", {15'h0, pmReq}, 16'h0000);
    checkOutput("s4_addr_50", {8'h00, pmAddr}, 16'h0050);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(1);
    checkOutput("s4_req_resume", {15'h0, pmReq}, 16'h0001);
    checkOutput("s4_addr_resume", {8'h00, pmAddr}, 16'h0050);
    tick(1);
    checkOutput("s4_valid_e2", {15'h0, segValid}, 16'h0000);
    tick(1);
    checkOutput("s4_valid_e3", {15'h0, segValid}, 16'h0001);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    $display("[TB] scenario 5: PC wrap-around");
    mem[8'h00] = 8'h10;
    expQ.push_back({16'h0B10, 8'h01});
    applyStimulus(1'b0, 1'b1, 8'hFF);
    tick(1);
    checkOutput("s5_valid_drop", {15'h0, segValid}, 16'h0000);
    checkOutput("s5_addr_ff", {8'h00, pmAddr}, 16'h00FF);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(2);
    checkOutput("s5_addr_wrap", {8'h00, pmAddr}, 16'h0000);
    tick(1);
    checkOutput("s5_valid", {15'h0, segValid}, 16'h0001);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(1);

    $display("[TB] scenario 6: asynchronous reset mid-transaction");
    mem[8'h00] = 8'h58;
    rst_n = 1'b0;
    waitCycles = 3;
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    checkOutput("s6_req_or", {15'h0, pmReq}, 16'h0001);
    checkOutput("s6_addr_or", {8'h00, pmAddr}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_req_async", {15'h0, pmReq}, 16'h0000);
    checkOutput("s6_valid_async", {15'h0, segValid}, 16'h0000);
    checkOutput("s6_addr_async", {8'h00, pmAddr}, 16'h0000);
    waitCycles = 0;
    tick(1);
    expQ.push_back({16'h582A, 8'h02});
    rst_n = 1'b1;
    tick(3);
    checkOutput("s6_valid_restart", {15'h0, segValid}, 16'h0001);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(3);

    checkOutput("all_segments_seen", 16'(expQ.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
